// File: rtl/loteria_pkg.sv
// Shared types and constants for the lottery round controller.
package loteria_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [3:0]  DIGIT_MAX  = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        DRAW,
        ARB,
        BET,
        EVAL,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        PR_NONE   = 2'b00,
        PR_FIRST  = 2'b01,
        PR_SECOND = 2'b10,
        PR_THIRD  = 2'b11
    } premio_t;

    // Element 0 is the first digit entered.
    typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

    // Decimal digits only; anything above nine is discarded at every input.
    function automatic logic digit_ok(input logic [3:0] d);
        return d <= DIGIT_MAX;
    endfunction

endpackage

// File: rtl/loteria_if.sv
// Operator/player panel and prize display signals of the lottery controller.
interface loteria_if #(
    parameter int unsigned CW = 5
);
    logic [3:0]    numero;
    logic          insere;
    logic          fim;
    logic [1:0]    req;
    logic [3:0]    dig_p1;
    logic          val_p1;
    logic [3:0]    dig_p2;
    logic          val_p2;
    logic [1:0]    gnt;
    logic [1:0]    premio;
    logic          premio_vld;
    logic [CW-1:0] p1;
    logic [CW-1:0] p2;
    logic [2:0]    jogos;
    logic          fim_jogo;

    // Panels side drives the inputs and watches the display.
    modport master (
        output numero, insere, fim, req, dig_p1, val_p1, dig_p2, val_p2,
        input  gnt, premio, premio_vld, p1, p2, jogos, fim_jogo
    );

    // Controller side.
    modport slave (
        input  numero, insere, fim, req, dig_p1, val_p1, dig_p2, val_p2,
        output gnt, premio, premio_vld, p1, p2, jogos, fim_jogo
    );
endinterface

// File: rtl/loteria_match.sv
// Combinational bet classifier: compares a 4-digit bet with the draw position by position.
module loteria_match
    import loteria_pkg::*;
(
    input  digits_t draw,
    input  digits_t bet,
    output premio_t premio
);

    logic [NUM_DIGITS-1:0] m;
    logic [2:0]            hits;

    // Per-position match vector, hit count and prize class.
    always_comb begin
        m    = '0;
        hits = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            m[i] = (bet[i] == draw[i]);
            hits = hits + {2'b00, m[i]};
        end
        if (&m) begin
            premio = PR_FIRST;
        end else if ((m[0] & m[1] & m[2]) | (m[1] & m[2] & m[3])) begin
            premio = PR_SECOND;
        end else if (hits >= 3'd2) begin
            premio = PR_THIRD;
        end else begin
            premio = PR_NONE;
        end
    end

endmodule

// File: rtl/loteria_ctrl.sv
// Lottery round sequencer: loads the draw, arbitrates the shared bet path between two
// players, classifies bets and keeps per-player prize tallies.
// Build option: LOTERIA_FIXED_PRIO_EN selects fixed priority (player1 wins ties) instead
// of round-robin arbitration.
module loteria_ctrl
    import loteria_pkg::*;
#(
    parameter int unsigned MAX_JOGOS = 5,
    parameter int unsigned CW        = 5
) (
    input  logic     clock,
    input  logic     reset,
    loteria_if.slave bus
);

    state_t        state_q, state_d;
    digits_t       draw_q, draw_d;
    digits_t       bet_q, bet_d;
    logic [1:0]    idx_q, idx_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          last_q, last_d;  // 1: player2 had the last grant
    premio_t       premio_q, premio_d;
    logic          premio_vld_q, premio_vld_d;
    logic [CW-1:0] p1_q, p1_d;
    logic [CW-1:0] p2_q, p2_d;
    logic [2:0]    jogos_q, jogos_d;
    premio_t       match_res;
    logic [1:0]    pick;
    logic [3:0]    bet_dig;
    logic          bet_val;
    logic          own_req;

    loteria_match u_match (
        .draw   (draw_q),
        .bet    (bet_q),
        .premio (match_res)
    );

    // Route only the granted player's digit path and request.
    always_comb begin
        bet_dig = gnt_q[1] ? bus.dig_p2 : bus.dig_p1;
        bet_val = (gnt_q[0] & bus.val_p1) | (gnt_q[1] & bus.val_p2);
        own_req = |(bus.req & gnt_q);
    end

    // Round FSM next state and datapath updates.
    always_comb begin
        state_d      = state_q;
        draw_d       = draw_q;
        bet_d        = bet_q;
        idx_d        = idx_q;
        gnt_d        = gnt_q;
        last_d       = last_q;
        premio_d     = premio_q;
        premio_vld_d = 1'b0;
        p1_d         = p1_q;
        p2_d         = p2_q;
        jogos_d      = jogos_q;
        pick         = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (bus.insere && digit_ok(bus.numero)) begin
                    draw_d[0] = bus.numero;
                    idx_d     = 2'd1;
                    state_d   = DRAW;
                end
            end
            DRAW: begin
                if (bus.insere && digit_ok(bus.numero)) begin
                    draw_d[idx_q] = bus.numero;
                    idx_d         = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = ARB;
                end
            end
            ARB: begin
                if (jogos_q == 3'(MAX_JOGOS) || bus.fim) begin
                    state_d = DONE;
                end else if (|bus.req) begin
`ifdef LOTERIA_FIXED_PRIO_EN
                    pick = bus.req[0] ? 2'b01 : 2'b10;
`else
                    if (bus.req == 2'b11) pick = last_q ? 2'b01 : 2'b10;
                    else                  pick = bus.req;
                    last_d = pick[1];
`endif
                    gnt_d   = pick;
                    idx_d   = 2'd0;
                    state_d = BET;
                end
            end
            BET: begin
                // Aborts take precedence over a digit arriving in the same cycle.
                if (bus.fim) begin
                    gnt_d   = 2'b00;
                    state_d = DONE;
                end else if (!own_req) begin
                    gnt_d   = 2'b00;
                    state_d = ARB;
                end else if (bet_val && digit_ok(bet_dig)) begin
                    bet_d[idx_q] = bet_dig;
                    idx_d        = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = EVAL;
                end
            end
            EVAL: begin
                premio_d     = match_res;
                premio_vld_d = 1'b1;
                if (match_res != PR_NONE) begin
                    if (gnt_q[0] && p1_q != {CW{1'b1}}) p1_d = p1_q + 1'b1;
                    if (gnt_q[1] && p2_q != {CW{1'b1}}) p2_d = p2_q + 1'b1;
                end
                jogos_d = jogos_q + 3'd1;
                gnt_d   = 2'b00;
                state_d = ARB;
            end
            DONE: begin
                if (bus.insere && digit_ok(bus.numero)) begin
                    jogos_d   = 3'd0;
                    premio_d  = PR_NONE;
                    draw_d[0] = bus.numero;
                    idx_d     = 2'd1;
                    state_d   = DRAW;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; player1 wins the first tie after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            draw_q       <= '0;
            bet_q        <= '0;
            idx_q        <= 2'd0;
            gnt_q        <= 2'b00;
            last_q       <= 1'b1;
            premio_q     <= PR_NONE;
            premio_vld_q <= 1'b0;
            p1_q         <= '0;
            p2_q         <= '0;
            jogos_q      <= 3'd0;
        end else begin
            state_q      <= state_d;
            draw_q       <= draw_d;
            bet_q        <= bet_d;
            idx_q        <= idx_d;
            gnt_q        <= gnt_d;
            last_q       <= last_d;
            premio_q     <= premio_d;
            premio_vld_q <= premio_vld_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            jogos_q      <= jogos_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.premio     = premio_q;
    assign bus.premio_vld = premio_vld_q;
    assign bus.p1         = p1_q;
    assign bus.p2         = p2_q;
    assign bus.jogos      = jogos_q;
    assign bus.fim_jogo   = (state_q == DONE);

endmodule

// File: tb/tb_loteria_ctrl.sv
// Directed bench for loteria_ctrl: inputs change on the falling edge, outputs are sampled there.
module tb_loteria_ctrl;
    import loteria_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    loteria_if #(.CW(5)) bus ();

    loteria_ctrl #(.MAX_JOGOS(5), .CW(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle_inputs();
        bus.numero = 4'd0; bus.insere = 1'b0; bus.fim = 1'b0; bus.req = 2'b00;
        bus.dig_p1 = 4'd0; bus.val_p1 = 1'b0; bus.dig_p2 = 4'd0; bus.val_p2 = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // dv holds digits little-end first: 16'h4321 is the sequence 1,2,3,4.
    task automatic load_draw(input logic [15:0] dv);
        for (int i = 0; i < 4; i++) begin
            bus.numero = dv[i*4 +: 4];
            bus.insere = 1'b1;
            @(negedge clock);
        end
        bus.insere = 1'b0;
    endtask

    // Starts in ARB; requests, checks the grant, enters four digits and checks the result.
    task automatic play_bet(input string tag, input int pl, input logic [1:0] reqv,
                            input logic [15:0] bv, input logic [1:0] exp_pr, input bit drop);
        logic [1:0] exp_g;
        exp_g = (pl == 1) ? 2'b01 : 2'b10;
        bus.req = reqv;
        @(negedge clock);
        n_cmp++;
        if (bus.gnt !== exp_g) begin
            n_err++; $display("FAIL %s gnt: got %b want %b", tag, bus.gnt, exp_g);
        end
        for (int i = 0; i < 4; i++) begin
            if (pl == 1) begin bus.dig_p1 = bv[i*4 +: 4]; bus.val_p1 = 1'b1; end
            else         begin bus.dig_p2 = bv[i*4 +: 4]; bus.val_p2 = 1'b1; end
            @(negedge clock);
        end
        bus.val_p1 = 1'b0;
        bus.val_p2 = 1'b0;
        if (drop) bus.req = 2'b00;
        @(negedge clock);
        n_cmp++;
        if (bus.premio_vld !== 1'b1 || bus.premio !== exp_pr || bus.gnt !== 2'b00) begin
            n_err++;
            $display("FAIL %s result: got vld=%b premio=%b gnt=%b want vld=1 premio=%b gnt=00",
                     tag, bus.premio_vld, bus.premio, bus.gnt, exp_pr);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        n_cmp++;
        if ({bus.gnt, bus.premio, bus.premio_vld, bus.p1, bus.p2, bus.jogos, bus.fim_jogo} !== '0)
        begin
            n_err++;
            $display("FAIL reset_outputs: got gnt=%b premio=%b vld=%b p1=%0d p2=%0d jogos=%0d fj=%b want all 0",
                     bus.gnt, bus.premio, bus.premio_vld, bus.p1, bus.p2, bus.jogos, bus.fim_jogo);
        end
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (bus.gnt !== 2'b00 || bus.fim_jogo !== 1'b0 || bus.premio_vld !== 1'b0) begin
            n_err++; $display("FAIL reset_release: got gnt=%b fj=%b vld=%b want 00/0/0",
                              bus.gnt, bus.fim_jogo, bus.premio_vld);
        end
    endtask

    task automatic test_exact();
        apply_reset();
        load_draw(16'h4321);
        play_bet("exact", 1, 2'b01, 16'h4321, PR_FIRST, 1'b1);
        n_cmp++;
        if (bus.p1 !== 5'd1 || bus.jogos !== 3'd1) begin
            n_err++; $display("FAIL exact_counts: got p1=%0d jogos=%0d want 1/1", bus.p1, bus.jogos);
        end
        @(negedge clock);
        n_cmp++;
        if (bus.premio_vld !== 1'b0 || bus.premio !== PR_FIRST) begin
            n_err++; $display("FAIL exact_pulse: got vld=%b premio=%b want 0/01",
                              bus.premio_vld, bus.premio);
        end
    endtask

    task automatic test_partial();
        apply_reset();
        load_draw(16'h4321);
        play_bet("second", 1, 2'b01, 16'h4329, PR_SECOND, 1'b1);
        play_bet("third", 1, 2'b01, 16'h0021, PR_THIRD, 1'b1);
        play_bet("none", 1, 2'b01, 16'h8765, PR_NONE, 1'b1);
        n_cmp++;
        if (bus.p1 !== 5'd2 || bus.p2 !== 5'd0 || bus.jogos !== 3'd3) begin
            n_err++; $display("FAIL partial_counts: got p1=%0d p2=%0d jogos=%0d want 2/0/3",
                              bus.p1, bus.p2, bus.jogos);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        load_draw(16'h4321);
        for (int k = 0; k < 4; k++) begin
            play_bet("rr", (k % 2 == 0) ? 1 : 2, 2'b11, 16'h4321, PR_FIRST, k == 3);
        end
        n_cmp++;
        if (bus.p1 !== 5'd2 || bus.p2 !== 5'd2 || bus.jogos !== 3'd4) begin
            n_err++; $display("FAIL rr_counts: got p1=%0d p2=%0d jogos=%0d want 2/2/4",
                              bus.p1, bus.p2, bus.jogos);
        end
    endtask

    task automatic test_abort();
        apply_reset();
        load_draw(16'h4321);
        bus.req = 2'b10;
        @(negedge clock);
        n_cmp++;
        if (bus.gnt !== 2'b10) begin
            n_err++; $display("FAIL abort_gnt: got %b want 10", bus.gnt);
        end
        // Player1 strobes while player2 holds the grant.
        bus.dig_p1 = 4'd1;
        bus.val_p1 = 1'b1;
        repeat (5) @(negedge clock);
        bus.val_p1 = 1'b0;
        n_cmp++;
        if (bus.jogos !== 3'd0 || bus.gnt !== 2'b10) begin
            n_err++; $display("FAIL other_ignored: got jogos=%0d gnt=%b want 0/10", bus.jogos, bus.gnt);
        end
        bus.dig_p2 = 4'd1; bus.val_p2 = 1'b1;
        @(negedge clock);
        bus.dig_p2 = 4'd2;
        @(negedge clock);
        bus.dig_p2 = 4'd3;
        bus.req    = 2'b00;
        @(negedge clock);
        bus.val_p2 = 1'b0;
        n_cmp++;
        if (bus.gnt !== 2'b00 || bus.premio_vld !== 1'b0) begin
            n_err++; $display("FAIL abort_drop: got gnt=%b vld=%b want 00/0", bus.gnt, bus.premio_vld);
        end
        @(negedge clock);
        n_cmp++;
        if (bus.premio_vld !== 1'b0 || bus.jogos !== 3'd0 || bus.p2 !== 5'd0) begin
            n_err++; $display("FAIL abort_nocount: got vld=%b jogos=%0d p2=%0d want 0/0/0",
                              bus.premio_vld, bus.jogos, bus.p2);
        end
        play_bet("after_abort", 2, 2'b10, 16'h4321, PR_FIRST, 1'b1);
        n_cmp++;
        if (bus.p2 !== 5'd1 || bus.jogos !== 3'd1) begin
            n_err++; $display("FAIL after_abort_counts: got p2=%0d jogos=%0d want 1/1", bus.p2, bus.jogos);
        end
    endtask

    task automatic test_fim();
        apply_reset();
        load_draw(16'h4321);
        bus.req = 2'b01;
        @(negedge clock);
        bus.dig_p1 = 4'd1; bus.val_p1 = 1'b1;
        @(negedge clock);
        bus.fim = 1'b1;
        @(negedge clock);
        bus.fim = 1'b0; bus.req = 2'b00; bus.val_p1 = 1'b0;
        n_cmp++;
        if (bus.gnt !== 2'b00 || bus.fim_jogo !== 1'b1 || bus.jogos !== 3'd0) begin
            n_err++; $display("FAIL fim_abort: got gnt=%b fj=%b jogos=%0d want 00/1/0",
                              bus.gnt, bus.fim_jogo, bus.jogos);
        end
    endtask

    task automatic test_done();
        apply_reset();
        load_draw(16'h4321);
        for (int k = 0; k < 5; k++) play_bet("round", 1, 2'b01, 16'h4321, PR_FIRST, 1'b1);
        @(negedge clock);
        n_cmp++;
        if (bus.fim_jogo !== 1'b1 || bus.jogos !== 3'd5 || bus.p1 !== 5'd5) begin
            n_err++; $display("FAIL done_enter: got fj=%b jogos=%0d p1=%0d want 1/5/5",
                              bus.fim_jogo, bus.jogos, bus.p1);
        end
        bus.req = 2'b01;
        repeat (3) @(negedge clock);
        n_cmp++;
        if (bus.gnt !== 2'b00 || bus.fim_jogo !== 1'b1) begin
            n_err++; $display("FAIL done_nogrant: got gnt=%b fj=%b want 00/1", bus.gnt, bus.fim_jogo);
        end
        bus.req = 2'b00;
        load_draw(16'h4321);
        n_cmp++;
        if (bus.jogos !== 3'd0 || bus.premio !== PR_NONE || bus.fim_jogo !== 1'b0 || bus.p1 !== 5'd5)
        begin
            n_err++; $display("FAIL new_round: got jogos=%0d premio=%b fj=%b p1=%0d want 0/00/0/5",
                              bus.jogos, bus.premio, bus.fim_jogo, bus.p1);
        end
        bus.req = 2'b01;
        @(negedge clock);
        bus.dig_p1 = 4'd1; bus.val_p1 = 1'b1;
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.gnt, bus.premio, bus.premio_vld, bus.p1, bus.p2, bus.jogos, bus.fim_jogo} !== '0)
        begin
            n_err++; $display("FAIL reset_mid_bet: got gnt=%b premio=%b p1=%0d jogos=%0d want all 0",
                              bus.gnt, bus.premio, bus.p1, bus.jogos);
        end
        idle_inputs();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int r = 0; r < 7; r++) begin
            load_draw(16'h4321);
            for (int b = 0; b < 5; b++) play_bet("sat", 1, 2'b01, 16'h4321, PR_FIRST, 1'b1);
            @(negedge clock);
        end
        n_cmp++;
        if (bus.p1 !== 5'd31 || bus.p2 !== 5'd0) begin
            n_err++; $display("FAIL saturate: got p1=%0d p2=%0d want 31/0", bus.p1, bus.p2);
        end
    endtask

    task automatic test_invalid();
        logic [19:0] seq;
        apply_reset();
        bus.numero = 4'd1; bus.insere = 1'b1;
        @(negedge clock);
        bus.numero = 4'd12;
        @(negedge clock);
        bus.numero = 4'd2;
        @(negedge clock);
        bus.numero = 4'd3;
        @(negedge clock);
        bus.insere = 1'b0;
        bus.req    = 2'b01;
        repeat (2) @(negedge clock);
        n_cmp++;
        if (bus.gnt !== 2'b00) begin
            n_err++; $display("FAIL invalid_draw_digit: got gnt=%b want 00", bus.gnt);
        end
        bus.numero = 4'd4; bus.insere = 1'b1;
        @(negedge clock);
        bus.insere = 1'b0;
        play_bet("invalid_draw", 1, 2'b01, 16'h4321, PR_FIRST, 1'b1);
        // Bet 1,2,10,3,4: the 10 must be skipped.
        seq = 20'h43A21;
        bus.req = 2'b01;
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            bus.dig_p1 = seq[i*4 +: 4]; bus.val_p1 = 1'b1;
            @(negedge clock);
        end
        bus.val_p1 = 1'b0; bus.req = 2'b00;
        @(negedge clock);
        n_cmp++;
        if (bus.premio_vld !== 1'b1 || bus.premio !== PR_FIRST || bus.p1 !== 5'd2) begin
            n_err++; $display("FAIL invalid_bet_digit: got vld=%b premio=%b p1=%0d want 1/01/2",
                              bus.premio_vld, bus.premio, bus.p1);
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_partial();
        test_round_robin();
        test_abort();
        test_fim();
        test_done();
        test_saturate();
        test_invalid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
